// File: rtl/simple_processor_pkg.sv
// Shared types and sizing for the processor's memory-side blocks.
// The data-memory controller state encoding lives here so that benches and monitors can decode it.
package simple_processor_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_WAIT  = 1;

  typedef enum logic [1:0] {DMEM_IDLE, DMEM_BUSY, DMEM_RESP} dmem_state_t;
endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the LOAD/STORE stage (master) and dmem_ctrl (slave).
interface dmem_if;
  import simple_processor_pkg::*;

  logic                  dmem_req_i;
  logic [DATA_WIDTH-1:0] dmem_addr_i;
  logic                  dmem_we_i;
  logic [DATA_WIDTH-1:0] dmem_wdata_i;
  logic [DATA_WIDTH-1:0] dmem_rd_o;
  logic                  dmem_ack_o;
  logic                  dmem_err_o;

  modport master (
    output dmem_req_i, dmem_addr_i, dmem_we_i, dmem_wdata_i,
    input  dmem_rd_o, dmem_ack_o, dmem_err_o
  );

  modport slave (
    input  dmem_req_i, dmem_addr_i, dmem_we_i, dmem_wdata_i,
    output dmem_rd_o, dmem_ack_o, dmem_err_o
  );
endinterface

// File: rtl/dmem_sram_1p.sv
// Single-port synchronous word RAM with registered read; contents are never reset.
module dmem_sram_1p #(
    parameter int    DEPTH      = 256,
    parameter int    DATA_WIDTH = 32,
    parameter string INIT_FILE  = ""
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) mem_q[idx_i] <= wdata_i;
            else      rdata_q      <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: latches one request in IDLE, waits WAIT_CYCLES, performs the access,
// then pulses ack for one cycle with load data or an error flag.
module dmem_ctrl
  import simple_processor_pkg::*;
#(
  parameter int    DEPTH       = DMEM_DEPTH,
  parameter int    WAIT_CYCLES = DMEM_WAIT,
  parameter string INIT_FILE   = ""
) (
  input  logic   clk_i,
  input  logic   arst_ni,
  dmem_if.slave  bus
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) << 2;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_ctrl: WAIT_CYCLES must be in 0..15");
  end

  dmem_state_t           state_q;
  logic [3:0]            cnt_q;
  logic [AW-1:0]         idx_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  bad_q;
  logic                  ack_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  resp_load_q;
  logic                  bad_d;
  logic                  ram_en;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign bad_d  = (bus.dmem_addr_i[1:0] != 2'b00) || (64'(bus.dmem_addr_i) >= ADDR_LIMIT);
  assign ram_en = (state_q == DMEM_BUSY) && (cnt_q == 4'd0) && !bad_q;

  dmem_sram_1p #(
    .DEPTH     (DEPTH),
    .DATA_WIDTH(DATA_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_sram (
    .clk_i  (clk_i),
    .en_i   (ram_en),
    .we_i   (we_q),
    .idx_i  (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= DMEM_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      bad_q       <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= '0;
      resp_load_q <= 1'b0;
    end else begin
      case (state_q)
        DMEM_IDLE: begin
          if (bus.dmem_req_i) begin
            idx_q   <= bus.dmem_addr_i[2 +: AW];
            we_q    <= bus.dmem_we_i;
            wdata_q <= bus.dmem_wdata_i;
            bad_q   <= bad_d;
            cnt_q   <= WAIT_INIT;
            state_q <= DMEM_BUSY;
          end
        end
        DMEM_BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            ack_q       <= 1'b1;
            err_q       <= bad_q;
            resp_load_q <= !we_q && !bad_q;
            if (bad_q) rd_q <= '0;
            state_q     <= DMEM_RESP;
          end
        end
        DMEM_RESP: begin
          // The RAM read register only becomes valid here, so fold it into rd_q on the way out.
          if (resp_load_q) rd_q <= ram_rdata;
          ack_q       <= 1'b0;
          err_q       <= 1'b0;
          resp_load_q <= 1'b0;
          state_q     <= DMEM_IDLE;
        end
        default: state_q <= DMEM_IDLE;
      endcase
    end
  end

  assign bus.dmem_ack_o = ack_q;
  assign bus.dmem_err_o = err_q;
  assign bus.dmem_rd_o  = resp_load_q ? ram_rdata : rd_q;
endmodule
